// File: rtl/wujian100_open_soc_top.sv
// Reduced FPGA pad-level top for the wujian100 SoC shell: reset synchronizer,
// clock-out, GPIO/USI loopback, 12-channel fixed-duty PWM with fault shutdown.
module wujian100_open_soc_top #(
    parameter int unsigned PWM_CNT_W = 10,
    parameter int unsigned DUTY_STEP = 64,
    parameter logic [1:0]  VADJ_SEL  = 2'b11
) (
    input  logic       clk,
    input  logic       PAD_MCURST,
    input  logic       PAD_JTAG_TCLK,
    input  logic       PAD_JTAG_TMS,
    inout  wire        PAD_GPIO_0,
    inout  wire        PAD_GPIO_1,
    inout  wire        PAD_GPIO_2,
    inout  wire        PAD_GPIO_3,
    inout  wire        PAD_GPIO_4,
    inout  wire        PAD_GPIO_5,
    inout  wire        PAD_GPIO_6,
    inout  wire        PAD_GPIO_7,
    inout  wire        PAD_GPIO_8,
    inout  wire        PAD_GPIO_9,
    inout  wire        PAD_GPIO_10,
    inout  wire        PAD_GPIO_11,
    inout  wire        PAD_GPIO_12,
    inout  wire        PAD_GPIO_13,
    inout  wire        PAD_GPIO_14,
    inout  wire        PAD_GPIO_15,
    inout  wire        PAD_GPIO_16,
    inout  wire        PAD_GPIO_17,
    inout  wire        PAD_GPIO_18,
    inout  wire        PAD_GPIO_19,
    inout  wire        PAD_GPIO_20,
    inout  wire        PAD_GPIO_21,
    inout  wire        PAD_GPIO_22,
    inout  wire        PAD_GPIO_23,
    inout  wire        PAD_GPIO_24,
    inout  wire        PAD_GPIO_25,
    inout  wire        PAD_GPIO_26,
    inout  wire        PAD_GPIO_27,
    inout  wire        PAD_GPIO_28,
    inout  wire        PAD_GPIO_29,
    inout  wire        PAD_GPIO_30,
    inout  wire        PAD_GPIO_31,
    output logic       PAD_PWM_CH0,
    output logic       PAD_PWM_CH1,
    output logic       PAD_PWM_CH2,
    output logic       PAD_PWM_CH3,
    output logic       PAD_PWM_CH4,
    output logic       PAD_PWM_CH5,
    output logic       PAD_PWM_CH6,
    output logic       PAD_PWM_CH7,
    output logic       PAD_PWM_CH8,
    output logic       PAD_PWM_CH9,
    output logic       PAD_PWM_CH10,
    output logic       PAD_PWM_CH11,
    input  logic       PAD_PWM_FAULT,
    output logic       PAD_USI0_NSS,
    output logic       PAD_USI0_SCLK,
    output logic       PAD_USI0_SD0,
    input  logic       PAD_USI0_SD1,
    output logic       PAD_USI1_NSS,
    output logic       PAD_USI1_SCLK,
    output logic       PAD_USI1_SD0,
    input  logic       PAD_USI1_SD1,
    output logic       PAD_USI2_NSS,
    output logic       PAD_USI2_SCLK,
    output logic       PAD_USI2_SD0,
    input  logic       PAD_USI2_SD1,
    output logic       POUT_EHS,
    output logic       vadj_en,
    output logic [1:0] set_vadj,
    inout  wire  [3:0] qspi_dq
);

    localparam int unsigned NUM_CH = 12;

    logic                 rst_n;
    logic [1:0]           r_rst_sync;
    logic [15:0]          w_gpio_in;
    logic [15:0]          r_gpio_s1;
    logic [15:0]          r_gpio_s2;
    logic [2:0]           w_usi_sd1;
    logic [2:0]           r_usi_s1;
    logic [2:0]           r_usi_s2;
    logic [PWM_CNT_W-1:0] r_cnt;
    logic [NUM_CH-1:0]    w_cmp;
    logic [NUM_CH-1:0]    r_pwm;
    logic [1:0]           r_flt_sync;
    logic                 r_fault;
    logic                 w_fault_now;
    logic                 r_ehs;
    logic                 r_vadj_en;
    logic                 w_unused_jtag;

    // Assertion follows the pad asynchronously; release is retimed by two flops.
    always_ff @(posedge clk or negedge PAD_MCURST) begin
        if (!PAD_MCURST) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign rst_n = r_rst_sync[1];

    assign w_gpio_in = {PAD_GPIO_15, PAD_GPIO_14, PAD_GPIO_13, PAD_GPIO_12,
                        PAD_GPIO_11, PAD_GPIO_10, PAD_GPIO_9,  PAD_GPIO_8,
                        PAD_GPIO_7,  PAD_GPIO_6,  PAD_GPIO_5,  PAD_GPIO_4,
                        PAD_GPIO_3,  PAD_GPIO_2,  PAD_GPIO_1,  PAD_GPIO_0};
    assign w_usi_sd1 = {PAD_USI2_SD1, PAD_USI1_SD1, PAD_USI0_SD1};

    // Thresholds are compared at 32 bits so a step past the period saturates high.
    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        w_cmp = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            w_cmp[n] = 32'(r_cnt) < ((n + 1) * DUTY_STEP);
        end
    end

    assign w_fault_now = r_fault | ~r_flt_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gpio_s1  <= '0;
            r_gpio_s2  <= '0;
            r_usi_s1   <= '0;
            r_usi_s2   <= '0;
            r_cnt      <= '0;
            r_pwm      <= '0;
            r_flt_sync <= 2'b11;
            r_fault    <= 1'b0;
            r_ehs      <= 1'b0;
            r_vadj_en  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; the synchronizer chains depend on it.
            r_gpio_s1  <= w_gpio_in;
            r_gpio_s2  <= r_gpio_s1;
            r_usi_s1   <= w_usi_sd1;
            r_usi_s2   <= r_usi_s1;
            r_cnt      <= r_cnt + 1'b1;
            r_pwm      <= w_fault_now ? '0 : w_cmp;
            r_flt_sync <= {r_flt_sync[0], PAD_PWM_FAULT};
            r_fault    <= w_fault_now;
            r_ehs      <= ~r_ehs;
            r_vadj_en  <= 1'b1;
        end
    end

    assign PAD_GPIO_16 = r_gpio_s2[0];
    assign PAD_GPIO_17 = r_gpio_s2[1];
    assign PAD_GPIO_18 = r_gpio_s2[2];
    assign PAD_GPIO_19 = r_gpio_s2[3];
    assign PAD_GPIO_20 = r_gpio_s2[4];
    assign PAD_GPIO_21 = r_gpio_s2[5];
    assign PAD_GPIO_22 = r_gpio_s2[6];
    assign PAD_GPIO_23 = r_gpio_s2[7];
    assign PAD_GPIO_24 = r_gpio_s2[8];
    assign PAD_GPIO_25 = r_gpio_s2[9];
    assign PAD_GPIO_26 = r_gpio_s2[10];
    assign PAD_GPIO_27 = r_gpio_s2[11];
    assign PAD_GPIO_28 = r_gpio_s2[12];
    assign PAD_GPIO_29 = r_gpio_s2[13];
    assign PAD_GPIO_30 = r_gpio_s2[14];
    assign PAD_GPIO_31 = r_gpio_s2[15];

    assign PAD_PWM_CH0  = r_pwm[0];
    assign PAD_PWM_CH1  = r_pwm[1];
    assign PAD_PWM_CH2  = r_pwm[2];
    assign PAD_PWM_CH3  = r_pwm[3];
    assign PAD_PWM_CH4  = r_pwm[4];
    assign PAD_PWM_CH5  = r_pwm[5];
    assign PAD_PWM_CH6  = r_pwm[6];
    assign PAD_PWM_CH7  = r_pwm[7];
    assign PAD_PWM_CH8  = r_pwm[8];
    assign PAD_PWM_CH9  = r_pwm[9];
    assign PAD_PWM_CH10 = r_pwm[10];
    assign PAD_PWM_CH11 = r_pwm[11];

    assign PAD_USI0_NSS  = 1'b1;
    assign PAD_USI1_NSS  = 1'b1;
    assign PAD_USI2_NSS  = 1'b1;
    assign PAD_USI0_SCLK = 1'b0;
    assign PAD_USI1_SCLK = 1'b0;
    assign PAD_USI2_SCLK = 1'b0;
    assign PAD_USI0_SD0  = r_usi_s2[0];
    assign PAD_USI1_SD0  = r_usi_s2[1];
    assign PAD_USI2_SD0  = r_usi_s2[2];

    assign POUT_EHS = r_ehs;
    assign vadj_en  = r_vadj_en;
    assign set_vadj = VADJ_SEL;
    assign qspi_dq  = 4'bzzzz;

    // JTAG pads are parked; the reduction only gives them a sink.
    assign w_unused_jtag = PAD_JTAG_TCLK & PAD_JTAG_TMS;

endmodule

// File: tb/tb_wujian100_open_soc_top.sv
// Bench for wujian100_open_soc_top: vector table, random stimulus against an
// edge-count reference model, and hand sequences for reset and fault corners.
module tb_wujian100_open_soc_top;

    localparam int PERIOD = 1024;
    localparam int STEP   = 64;

    logic        clk = 1'b0;
    logic        mcurst;
    logic        tclk;
    logic        tms;
    logic        fault;
    logic [15:0] gpio_drv;
    logic [2:0]  sd1;
    wire  [31:0] gpio;
    wire  [11:0] pwm;
    wire  [2:0]  nss;
    wire  [2:0]  sclk;
    wire  [2:0]  sd0;
    wire         ehs;
    wire         vadj;
    wire  [1:0]  setv;
    wire  [3:0]  qspi;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    assign gpio[15:0] = gpio_drv;

    wujian100_open_soc_top dut (
        .clk(clk), .PAD_MCURST(mcurst), .PAD_JTAG_TCLK(tclk), .PAD_JTAG_TMS(tms),
        .PAD_GPIO_0(gpio[0]),   .PAD_GPIO_1(gpio[1]),   .PAD_GPIO_2(gpio[2]),   .PAD_GPIO_3(gpio[3]),
        .PAD_GPIO_4(gpio[4]),   .PAD_GPIO_5(gpio[5]),   .PAD_GPIO_6(gpio[6]),   .PAD_GPIO_7(gpio[7]),
        .PAD_GPIO_8(gpio[8]),   .PAD_GPIO_9(gpio[9]),   .PAD_GPIO_10(gpio[10]), .PAD_GPIO_11(gpio[11]),
        .PAD_GPIO_12(gpio[12]), .PAD_GPIO_13(gpio[13]), .PAD_GPIO_14(gpio[14]), .PAD_GPIO_15(gpio[15]),
        .PAD_GPIO_16(gpio[16]), .PAD_GPIO_17(gpio[17]), .PAD_GPIO_18(gpio[18]), .PAD_GPIO_19(gpio[19]),
        .PAD_GPIO_20(gpio[20]), .PAD_GPIO_21(gpio[21]), .PAD_GPIO_22(gpio[22]), .PAD_GPIO_23(gpio[23]),
        .PAD_GPIO_24(gpio[24]), .PAD_GPIO_25(gpio[25]), .PAD_GPIO_26(gpio[26]), .PAD_GPIO_27(gpio[27]),
        .PAD_GPIO_28(gpio[28]), .PAD_GPIO_29(gpio[29]), .PAD_GPIO_30(gpio[30]), .PAD_GPIO_31(gpio[31]),
        .PAD_PWM_CH0(pwm[0]),   .PAD_PWM_CH1(pwm[1]),   .PAD_PWM_CH2(pwm[2]),   .PAD_PWM_CH3(pwm[3]),
        .PAD_PWM_CH4(pwm[4]),   .PAD_PWM_CH5(pwm[5]),   .PAD_PWM_CH6(pwm[6]),   .PAD_PWM_CH7(pwm[7]),
        .PAD_PWM_CH8(pwm[8]),   .PAD_PWM_CH9(pwm[9]),   .PAD_PWM_CH10(pwm[10]), .PAD_PWM_CH11(pwm[11]),
        .PAD_PWM_FAULT(fault),
        .PAD_USI0_NSS(nss[0]), .PAD_USI0_SCLK(sclk[0]), .PAD_USI0_SD0(sd0[0]), .PAD_USI0_SD1(sd1[0]),
        .PAD_USI1_NSS(nss[1]), .PAD_USI1_SCLK(sclk[1]), .PAD_USI1_SD0(sd0[1]), .PAD_USI1_SD1(sd1[1]),
        .PAD_USI2_NSS(nss[2]), .PAD_USI2_SCLK(sclk[2]), .PAD_USI2_SD0(sd0[2]), .PAD_USI2_SD1(sd1[2]),
        .POUT_EHS(ehs), .vadj_en(vadj), .set_vadj(setv), .qspi_dq(qspi)
    );

    // Reference model: counts edges since pad release and keeps a history of sampled inputs.
    int          k;
    int          m;
    int          fault_edge;
    logic [15:0] g_hist[$];
    logic [2:0]  u_hist[$];

    task automatic model_reset();
        k = 0;
        m = 0;
        fault_edge = -1;
        g_hist.delete();
        u_hist.delete();
    endtask

    task automatic model_edge();
        if (!mcurst) begin
            model_reset();
        end else begin
            k++;
            if (k >= 3) begin
                m++;
                g_hist.push_back(gpio_drv);
                u_hist.push_back(sd1);
                if (g_hist.size() > 4) void'(g_hist.pop_front());
                if (u_hist.size() > 4) void'(u_hist.pop_front());
                if (!fault && fault_edge < 0) fault_edge = m;
            end
        end
    endtask

    function automatic logic [11:0] exp_pwm();
        logic [11:0] e;
        int cnt;
        e = '0;
        if (m == 0) return e;
        if (fault_edge >= 0 && m >= fault_edge + 2) return e;
        cnt = (m - 1) % PERIOD;
        for (int n = 0; n < 12; n++) e[n] = (cnt < (n + 1) * STEP);
        return e;
    endfunction

    function automatic logic [15:0] exp_gpio();
        if (g_hist.size() < 2) return 16'h0000;
        return g_hist[g_hist.size() - 2];
    endfunction

    function automatic logic [2:0] exp_usi();
        if (u_hist.size() < 2) return 3'b000;
        return u_hist[u_hist.size() - 2];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("pwm", 64'(pwm), 64'(exp_pwm()));
        check("pout_ehs", 64'(ehs), 64'(m % 2));
        check("vadj_en", 64'(vadj), 64'(m >= 1));
        check("set_vadj", 64'(setv), 64'(2'b11));
        check("gpio_out", 64'(gpio[31:16]), 64'(exp_gpio()));
        check("gpio_in_undriven", 64'(gpio[15:0]), 64'(gpio_drv));
        check("usi_sd0", 64'(sd0), 64'(exp_usi()));
        check("usi_nss", 64'(nss), 64'(3'b111));
        check("usi_sclk", 64'(sclk), 64'(3'b000));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #5;
        compare_all();
    endtask

    task automatic wait_cnt(input int target);
        bit reached;
        reached = 0;
        for (int i = 0; i < 1100 && !reached; i++) begin
            cycle();
            reached = (m >= 1) && (((m - 1) % PERIOD) == target);
        end
        check("wait_cnt_timeout", 64'(reached), 64'(1));
    endtask

    typedef struct {
        logic [15:0] g_in;
        logic [2:0]  u_in;
        logic [15:0] g_exp;
        logic [2:0]  u_exp;
    } vec_t;

    vec_t vecs[6];
    int   hi_cnt[12];

    initial begin
        vecs[0] = '{16'hA5C3, 3'b010, 16'hA5C3, 3'b010};
        vecs[1] = '{16'hFFFF, 3'b111, 16'hFFFF, 3'b111};
        vecs[2] = '{16'h0000, 3'b000, 16'h0000, 3'b000};
        vecs[3] = '{16'h1234, 3'b101, 16'h1234, 3'b101};
        vecs[4] = '{16'h8001, 3'b100, 16'h8001, 3'b100};
        vecs[5] = '{16'h5A3C, 3'b001, 16'h5A3C, 3'b001};

        mcurst = 1'b0;
        tclk = 1'b0;
        tms = 1'b1;
        fault = 1'b1;
        gpio_drv = 16'h0000;
        sd1 = 3'b000;
        model_reset();

        // 20 us of reset with busy inputs: outputs must sit at reset values.
        for (int i = 0; i < 1000; i++) begin
            gpio_drv = 16'($urandom);
            sd1 = 3'($urandom);
            cycle();
        end
        gpio_drv = 16'h0000;
        sd1 = 3'b000;

        mcurst = 1'b1;
        cycle();
        cycle();
        check("vadj_before_3rd_edge", 64'(vadj), 64'(0));
        check("ehs_before_3rd_edge", 64'(ehs), 64'(0));
        cycle();
        check("vadj_at_3rd_edge", 64'(vadj), 64'(1));
        check("ehs_at_3rd_edge", 64'(ehs), 64'(1));
        check("pwm_first_high", 64'(pwm), 64'(12'hFFF));

        for (int i = 0; i < 6; i++) begin
            gpio_drv = vecs[i].g_in;
            sd1 = vecs[i].u_in;
            cycle();
            cycle();
            check("tbl_gpio", 64'(gpio[31:16]), 64'(vecs[i].g_exp));
            check("tbl_usi", 64'(sd0), 64'(vecs[i].u_exp));
        end

        for (int i = 0; i < 3000; i++) begin
            gpio_drv = 16'($urandom);
            sd1 = 3'($urandom);
            tclk = 1'($urandom);
            tms = 1'($urandom);
            cycle();
        end
        tms = 1'b1;

        // Two full periods from an arbitrary phase: each channel's high time is exact.
        for (int n = 0; n < 12; n++) hi_cnt[n] = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            cycle();
            for (int n = 0; n < 12; n++) hi_cnt[n] += int'(pwm[n]);
        end
        for (int n = 0; n < 12; n++) begin
            check($sformatf("duty_ch%0d", n), 64'(hi_cnt[n]),
                  64'(2 * (((n + 1) * STEP < PERIOD) ? (n + 1) * STEP : PERIOD)));
        end

        // One-cycle fault pulse mid-period: sticky shutdown within three edges.
        wait_cnt(20);
        check("pre_fault_pwm", 64'(pwm), 64'(12'hFFF));
        fault = 1'b0;
        cycle();
        fault = 1'b1;
        cycle();
        cycle();
        check("fault_off_3_edges", 64'(pwm), 64'(0));
        for (int i = 0; i < 1100; i++) cycle();
        check("fault_sticky", 64'(pwm), 64'(0));

        mcurst = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (4) cycle();
        mcurst = 1'b1;
        for (int i = 0; i < 1100; i++) cycle();

        // Asynchronous reset while every channel is high, between clock edges.
        wait_cnt(5);
        check("pre_async_pwm", 64'(pwm), 64'(12'hFFF));
        mcurst = 1'b0;
        #1;
        check("async_pwm_drop", 64'(pwm), 64'(0));
        check("async_ehs_drop", 64'(ehs), 64'(0));
        check("async_vadj_drop", 64'(vadj), 64'(0));
        model_reset();
        compare_all();
        repeat (5) cycle();
        mcurst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            gpio_drv = 16'($urandom);
            sd1 = 3'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
